change_return_sequencer: RTL and testbench

- Sequences the coin-return path after a vend or cancel. Takes a change amount in cents and issues one coin per handshake to the coin ejector.
- Coin choice is greedy: the largest denomination that fits the remaining amount and is in stock.
- Tracks per-denomination coin inventory and reports short-change and ejector-jam faults.
- Sits between the vending FSM (start/done) and the physical coin ejector.

---
 rtl/change_return_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_change_return_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_return_sequencer.sv
// change_return_sequencer
//   Returns change as a series of single-coin handshakes to the coin ejector.
//   It picks coins greedily (largest denomination that fits and is in stock),
//   keeps a per-denomination inventory and reports short-change and ejector-jam
//   faults back to the vending FSM.
//
// Ports
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   start, amount        : change request (accepted only while idle)
//   coin_ack             : ejector released the presented coin
//   refill_en/code/count : add coins to one denomination's inventory
//   inv_sel, inv_count   : combinational inventory readback
//   busy, coin_valid,
//   coin_code            : sequencer status and coin presented to ejector
//   done, fault          : one-cycle completion / abort pulses
//   fault_jam            : fault cause (1 = ack timeout, 0 = short change)
//   remaining            : cents still owed
//
// Denomination codes: 1=1c 2=5c 3=10c 4=25c 5=50c 6=100c; 0 and 7 are unused.
module change_return_sequencer #(
  parameter int AMT_W       = 10,
  parameter int INV_W       = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  input  logic             refill_en,
  input  logic [2:0]       refill_code,
  input  logic [INV_W-1:0] refill_count,
  input  logic [2:0]       inv_sel,
  output logic             busy,
  output logic             coin_valid,
  output logic [2:0]       coin_code,
  output logic             done,
  output logic             fault,
  output logic             fault_jam,
  output logic [AMT_W-1:0] remaining,
  output logic [INV_W-1:0] inv_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_EJECT  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  // Timer only needs to reach ACK_TIMEOUT-1.
  localparam int              TMR_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [INV_W-1:0] INV_MAX  = '1;

  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] d);
    case (d)
      3'd1:    return AMT_W'(1);
      3'd2:    return AMT_W'(5);
      3'd3:    return AMT_W'(10);
      3'd4:    return AMT_W'(25);
      3'd5:    return AMT_W'(50);
      3'd6:    return AMT_W'(100);
      default: return '0;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [2:0]       coin_code_q, coin_code_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             fault_jam_q, fault_jam_d;
  logic [INV_W-1:0] inv_q [1:6];
  logic [INV_W-1:0] inv_d [1:6];

  logic             ack_take;
  logic [2:0]       pick;
  logic [INV_W:0]   sum;

  assign ack_take = (state_q == S_EJECT) && coin_ack;

  // Greedy choice: ascending scan, so the last qualifying code is the largest.
  always_comb begin
    pick = 3'd0;
    for (int d = 1; d <= 6; d++) begin
      if (inv_q[d] != '0 && coin_value(3'(d)) <= remaining_q) pick = 3'(d);
    end
  end

  // Refill and ack decrement on the same code combine into one saturated result.
  always_comb begin
    sum = '0;
    for (int d = 1; d <= 6; d++) begin
      sum = {1'b0, inv_q[d]};
      if (refill_en && refill_code == 3'(d)) sum = sum + {1'b0, refill_count};
      if (ack_take && coin_code_q == 3'(d))  sum = sum - (INV_W+1)'(1);
      inv_d[d] = (sum > {1'b0, INV_MAX}) ? INV_MAX : sum[INV_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_code_d = coin_code_q;
    timer_d     = timer_q;
    fault_jam_d = fault_jam_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = amount;
          fault_jam_d = 1'b0;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (pick != 3'd0) begin
          coin_code_d = pick;
          timer_d     = '0;
          state_d     = S_EJECT;
        end else begin
          fault_jam_d = 1'b0;
          state_d     = S_FAULT;
        end
      end
      S_EJECT: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(coin_code_q);
          state_d     = S_SELECT;
        end else if (timer_q == TMR_LAST) begin
          fault_jam_d = 1'b1;
          state_d     = S_FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      coin_code_q <= 3'd0;
      timer_q     <= '0;
      fault_jam_q <= 1'b0;
      for (int d = 1; d <= 6; d++) inv_q[d] <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_code_q <= coin_code_d;
      timer_q     <= timer_d;
      fault_jam_q <= fault_jam_d;
      for (int d = 1; d <= 6; d++) inv_q[d] <= inv_d[d];
    end
  end

  always_comb begin
    case (inv_sel)
      3'd1:    inv_count = inv_q[1];
      3'd2:    inv_count = inv_q[2];
      3'd3:    inv_count = inv_q[3];
      3'd4:    inv_count = inv_q[4];
      3'd5:    inv_count = inv_q[5];
      3'd6:    inv_count = inv_q[6];
      default: inv_count = '0;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign coin_valid = (state_q == S_EJECT);
  assign done       = (state_q == S_DONE);
  assign fault      = (state_q == S_FAULT);
  assign fault_jam  = fault_jam_q;
  assign coin_code  = coin_code_q;
  assign remaining  = remaining_q;

endmodule

// File: tb/tb_change_return_sequencer.sv
module tb_change_return_sequencer;

  localparam int AMT_W = 10;
  localparam int INV_W = 8;
  localparam int ACK_TIMEOUT = 4;
  localparam int INV_SAT = 255;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             coin_ack;
  logic             refill_en;
  logic [2:0]       refill_code;
  logic [INV_W-1:0] refill_count;
  logic [2:0]       inv_sel;
  logic             busy, coin_valid, done, fault, fault_jam;
  logic [2:0]       coin_code;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] inv_count;

  change_return_sequencer #(.AMT_W(AMT_W), .INV_W(INV_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .amount(amount), .coin_ack(coin_ack),
    .refill_en(refill_en), .refill_code(refill_code), .refill_count(refill_count),
    .inv_sel(inv_sel), .busy(busy), .coin_valid(coin_valid), .coin_code(coin_code),
    .done(done), .fault(fault), .fault_jam(fault_jam), .remaining(remaining),
    .inv_count(inv_count)
  );

  always #5 clock = ~clock;

  // ---------------- stimulus plumbing ----------------
  logic             pre_en;
  logic [2:0]       pre_code;
  logic [INV_W-1:0] pre_count;
  logic             ack_ref_en;
  logic             auto_ack;
  logic             ref_mode;
  int               ref_base;
  logic             rot;
  logic [2:0]       sel_req;
  logic [2:0]       rot_cnt = 3'd0;
  int               vcnt;
  int               codes[$];

  assign refill_en    = pre_en | ack_ref_en;
  assign refill_code  = ack_ref_en ? 3'd1 : pre_code;
  assign refill_count = ack_ref_en ? INV_W'(10) : pre_count;
  assign inv_sel      = rot ? rot_cnt : sel_req;

  always @(posedge clock) rot_cnt <= rot_cnt + 3'd1;

  // Auto-acknowledge each coin on its second presented cycle.
  initial begin
    coin_ack = 1'b0;
    ack_ref_en = 1'b0;
    vcnt = 0;
    forever begin
      @(negedge clock);
      if (coin_valid === 1'b1) vcnt++;
      else vcnt = 0;
      if (auto_ack && vcnt == 2) begin
        coin_ack   = 1'b1;
        ack_ref_en = ref_mode && (codes.size() == ref_base);
        codes.push_back(int'(coin_code));
      end else begin
        coin_ack   = 1'b0;
        ack_ref_en = 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {P_IDLE, P_THINK, P_WAIT, P_OK, P_ABORT} phase_t;
  int     coin_val[7] = '{0, 1, 5, 10, 25, 50, 100};
  phase_t m_phase = P_IDLE;
  int     m_inv[1:6];
  int     m_rem, m_code, m_waited;
  bit     m_jam;
  int     nv[1:6];
  bit     cmp_en = 1'b0;

  function automatic int greedy(input int rem);
    for (int d = 6; d >= 1; d--)
      if (m_inv[d] > 0 && coin_val[d] <= rem) return d;
    return 0;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_phase = P_IDLE; m_rem = 0; m_code = 0; m_waited = 0; m_jam = 0;
      for (int d = 1; d <= 6; d++) m_inv[d] = 0;
    end else begin
      for (int d = 1; d <= 6; d++) begin
        nv[d] = m_inv[d];
        if (refill_en && int'(refill_code) == d) nv[d] += int'(refill_count);
        if (m_phase == P_WAIT && coin_ack && m_code == d) nv[d] -= 1;
        if (nv[d] > INV_SAT) nv[d] = INV_SAT;
      end
      case (m_phase)
        P_IDLE: if (start) begin m_rem = int'(amount); m_jam = 0; m_phase = P_THINK; end
        P_THINK: begin
          if (m_rem == 0) m_phase = P_OK;
          else if (greedy(m_rem) == 0) begin m_jam = 0; m_phase = P_ABORT; end
          else begin m_code = greedy(m_rem); m_waited = 1; m_phase = P_WAIT; end
        end
        P_WAIT: begin
          if (coin_ack) begin m_rem -= coin_val[m_code]; m_phase = P_THINK; end
          else if (m_waited == ACK_TIMEOUT) begin m_jam = 1; m_phase = P_ABORT; end
          else m_waited++;
        end
        default: m_phase = P_IDLE;
      endcase
      for (int d = 1; d <= 6; d++) m_inv[d] = nv[d];
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
      chk("coin_valid", 32'(coin_valid), 32'(m_phase == P_WAIT));
      chk("done", 32'(done), 32'(m_phase == P_OK));
      chk("fault", 32'(fault), 32'(m_phase == P_ABORT));
      chk("remaining", 32'(remaining), 32'(m_rem));
      if (m_phase == P_WAIT) chk("coin_code", 32'(coin_code), 32'(m_code));
      if (m_phase == P_ABORT) chk("fault_jam", 32'(fault_jam), 32'(m_jam));
      chk("inv_count", 32'(inv_count),
          (inv_sel >= 3'd1 && inv_sel <= 3'd6) ? 32'(m_inv[int'(inv_sel)]) : 32'd0);
    end
  end

  // ---------------- directed tasks ----------------
  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic refill(input int code, input int cnt);
    @(posedge clock); #1;
    pre_en = 1'b1; pre_code = 3'(code); pre_count = INV_W'(cnt);
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_start(input int a);
    @(posedge clock); #1;
    start = 1'b1; amount = AMT_W'(a);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget,
                          output bit got_done, output bit got_fault,
                          output int nvalid, output int first_valid, output int end_at);
    got_done = 0; got_fault = 0; nvalid = 0; first_valid = 0; end_at = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (coin_valid === 1'b1) begin
        nvalid++;
        if (first_valid == 0) first_valid = i;
      end
      if (done === 1'b1) begin got_done = 1; end_at = i; break; end
      if (fault === 1'b1) begin got_fault = 1; end_at = i; break; end
    end
    if (!got_done && !got_fault) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: no done/fault within %0d cycles", tag, budget);
    end
  endtask

  task automatic read_inv(input string name, input int code, input int exp);
    rot = 1'b0; sel_req = 3'(code);
    #1;
    chk(name, 32'(inv_count), 32'(exp));
    rot = 1'b1;
  endtask

  task automatic chk_codes(input string tag, input int base, input int exp[$]);
    chk({tag, " ncoins"}, 32'(codes.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (base + i < codes.size())
        chk($sformatf("%s code%0d", tag, i), 32'(codes[base + i]), 32'(exp[i]));
  endtask

  bit gd, gf;
  int nvl, fv, ea, base;

  initial begin
    reset = 1'b1; start = 1'b0; amount = '0;
    pre_en = 1'b0; pre_code = 3'd0; pre_count = '0;
    auto_ack = 1'b0; ref_mode = 1'b0; ref_base = 0;
    rot = 1'b1; sel_req = 3'd0;
    repeat (2) @(posedge clock);
    #1 cmp_en = 1'b1;
    @(negedge clock);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst coin_valid", 32'(coin_valid), 32'd0);
    chk("rst remaining", 32'(remaining), 32'd0);
    chk("rst fault_jam", 32'(fault_jam), 32'd0);
    read_inv("rst inv1", 1, 0);
    @(posedge clock); #1 reset = 1'b0;

    // 41c from full stock: 25+10+5+1
    for (int d = 1; d <= 6; d++) refill(d, 10);
    auto_ack = 1'b1; base = codes.size();
    do_start(41);
    wait_end("t1", 60, gd, gf, nvl, fv, ea);
    chk("t1 done", 32'(gd), 32'd1);
    chk("t1 first_valid latency", 32'(fv), 32'd2);
    chk("t1 remaining", 32'(remaining), 32'd0);
    chk_codes("t1", base, '{4, 3, 2, 1});
    for (int d = 1; d <= 4; d++) read_inv($sformatf("t1 inv%0d", d), d, 9);
    read_inv("t1 inv6", 6, 10);
    read_inv("t1 inv7", 7, 0);

    // 30c with only dimes
    do_reset(); refill(3, 3); base = codes.size();
    do_start(30);
    wait_end("t2", 60, gd, gf, nvl, fv, ea);
    chk("t2 done", 32'(gd), 32'd1);
    chk_codes("t2", base, '{3, 3, 3});
    read_inv("t2 inv3", 3, 0);

    // 7c with one nickel and one penny: short change, 1c undelivered
    do_reset(); refill(2, 1); refill(1, 1); refill(7, 9); base = codes.size();
    do_start(7);
    wait_end("t3", 60, gd, gf, nvl, fv, ea);
    chk("t3 fault", 32'(gf), 32'd1);
    chk("t3 fault_jam", 32'(fault_jam), 32'd0);
    chk("t3 remaining", 32'(remaining), 32'd1);
    chk_codes("t3", base, '{2, 1});
    read_inv("t3 inv2", 2, 0);
    read_inv("t3 inv1", 1, 0);

    // no ack at all: jam after ACK_TIMEOUT presented cycles
    do_reset(); refill(1, 5); auto_ack = 1'b0;
    do_start(3);
    wait_end("t4", 60, gd, gf, nvl, fv, ea);
    chk("t4 fault", 32'(gf), 32'd1);
    chk("t4 valid cycles", 32'(nvl), 32'd4);
    chk("t4 fault_jam", 32'(fault_jam), 32'd1);
    chk("t4 remaining", 32'(remaining), 32'd3);
    read_inv("t4 inv1", 1, 5);
    @(negedge clock);
    chk("t4 fault_jam holds", 32'(fault_jam), 32'd1);

    // saturated penny stock, refill on first ack: 255+10-1 -> 255, then 254
    do_reset(); refill(1, 255); auto_ack = 1'b1;
    base = codes.size(); ref_base = base; ref_mode = 1'b1;
    do_start(2);
    wait_end("t5", 60, gd, gf, nvl, fv, ea);
    ref_mode = 1'b0;
    chk("t5 done", 32'(gd), 32'd1);
    chk_codes("t5", base, '{1, 1});
    read_inv("t5 inv1", 1, 254);

    // zero amount: done two cycles after accept, no coin
    do_reset();
    do_start(0);
    wait_end("t6", 20, gd, gf, nvl, fv, ea);
    chk("t6 done", 32'(gd), 32'd1);
    chk("t6 done latency", 32'(ea), 32'd2);
    chk("t6 no coin", 32'(nvl), 32'd0);

    // start while in DONE is dropped
    do_start(0);
    @(posedge clock); #1 start = 1'b1; amount = AMT_W'(5);
    @(posedge clock); #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("t7 idle%0d", i), 32'(busy), 32'd0);
    end

    // reset in the middle of EJECT
    refill(1, 5); auto_ack = 1'b0;
    do_start(3);
    for (int i = 0; i < 10 && coin_valid !== 1'b1; i++) @(negedge clock);
    chk("t8 reached eject", 32'(coin_valid), 32'd1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("t8 busy", 32'(busy), 32'd0);
    chk("t8 coin_valid", 32'(coin_valid), 32'd0);
    for (int d = 1; d <= 6; d++) read_inv($sformatf("t8 inv%0d", d), d, 0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
